// File: rtl/pdm_capture_sequencer.sv
// -----------------------------------------------------------------------------
// pdm_capture_sequencer
//
// Run/stop sequencer for the PDM mic-array capture path (pdm_clk domain).
// Gates the microphone clock, throws away samples taken while the mics are
// still waking up, masks disabled channels and forwards the raw channel
// bit-vectors as framed AXI-Stream beats. The capture side cannot stall, so
// a 2-entry output buffer absorbs downstream backpressure and samples that do
// not fit are dropped and counted.
//
// Ports
//   pdm_clk         capture clock, rising edge
//   io_reset        asynchronous active-high reset
//   enable          level, 1 = capture requested
//   chan_mask       per-channel enable, 0 forces that data bit to 0
//   s_axis_tvalid   sample strobe from the capture path (no tready)
//   s_axis_tdata    raw channel bits
//   mic_clk_en      enables the mic clock output driver
//   m_axis_*        output stream (tvalid/tready/tdata/tlast)
//   busy            sequencer is not idle
//   overflow_count  dropped samples since reset, saturating
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | mic clock off, input ignored, waiting for enable
// WAKE  | mic clock running, samples discarded until wake-up time elapses
// RUN   | every input sample is masked and pushed into the output buffer
// STOP  | finish the current frame, then drain the buffer and go idle
// -----------------------------------------------------------------------------
module pdm_capture_sequencer #(
    parameter int NUM_MIC_PAIRS    = 4,
    parameter int AXI_STREAM_BYTES = 1,
    parameter int WAKE_CYCLES      = 48000,
    parameter int FRAME_LEN        = 256
) (
    input  logic                            pdm_clk,
    input  logic                            io_reset,
    input  logic                            enable,
    input  logic [2*NUM_MIC_PAIRS-1:0]      chan_mask,
    input  logic                            s_axis_tvalid,
    input  logic [8*AXI_STREAM_BYTES-1:0]   s_axis_tdata,
    output logic                            mic_clk_en,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [8*AXI_STREAM_BYTES-1:0]   m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic                            busy,
    output logic [15:0]                     overflow_count
);

    localparam int DW  = 8 * AXI_STREAM_BYTES;
    localparam int CW  = 2 * NUM_MIC_PAIRS;
    localparam int WCW = $clog2(WAKE_CYCLES + 1);
    localparam int FCW = $clog2(FRAME_LEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAKE = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [WCW-1:0] wake_cnt_q, wake_cnt_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [15:0]    ovf_cnt_q, ovf_cnt_d;
    logic [1:0]     count_q, count_d;
    logic [DW:0]    head_q, head_d;
    logic [DW:0]    tail_q, tail_d;

    logic           push, pop, accept, drop, is_last;
    logic [DW-1:0]  masked;
    logic [DW:0]    entry;

    always_comb begin
        masked = '0;
        masked[CW-1:0] = s_axis_tdata[CW-1:0] & chan_mask;
    end

    assign is_last = (frame_cnt_q == FCW'(FRAME_LEN - 1));
    assign entry   = {is_last, masked};

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_WAKE;
                    wake_cnt_d = WCW'(WAKE_CYCLES - 1);
                end
            end
            S_WAKE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (wake_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q - WCW'(1);
                end
            end
            S_RUN: begin
                push = s_axis_tvalid;
                if (!enable) begin
                    state_d = S_STOP;
                end
            end
            default: begin
                // A zero frame count means we sit on a frame boundary, so
                // nothing more is pushed; wait for the buffer to empty.
                if (frame_cnt_q != '0) begin
                    push = s_axis_tvalid;
                end else if (count_q == 2'd0) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    assign pop    = (count_q != 2'd0) && m_axis_tready;
    assign accept = push && ((count_q != 2'd2) || pop);
    assign drop   = push && !accept;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (accept) begin
            frame_cnt_d = is_last ? '0 : frame_cnt_q + FCW'(1);
        end
        ovf_cnt_d = ovf_cnt_q;
        if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    // Two-entry buffer; the head register drives the stream outputs directly.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({accept, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = entry;
                end else begin
                    tail_d = entry;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = entry;
                end else begin
                    head_d = tail_q;
                    tail_d = entry;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pdm_clk or posedge io_reset) begin
        if (io_reset) begin
            state_q     <= S_IDLE;
            wake_cnt_q  <= '0;
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
            count_q     <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            state_q     <= state_d;
            wake_cnt_q  <= wake_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign mic_clk_en     = busy;
    assign m_axis_tvalid  = (count_q != 2'd0);
    assign m_axis_tdata   = head_q[DW-1:0];
    assign m_axis_tlast   = head_q[DW];
    assign overflow_count = ovf_cnt_q;

endmodule

// File: tb/tb_pdm_capture_sequencer.sv
// Bench for pdm_capture_sequencer: directed scenarios followed by a random
// phase. A behavioural model predicts accepted beats (pushed into a queue),
// drops and sequencer activity; a separate monitor pops and compares beats.
module tb_pdm_capture_sequencer;

    localparam int NP   = 4;
    localparam int NB   = 1;
    localparam int WAKE = 4;
    localparam int FL   = 4;

    logic        pdm_clk;
    logic        io_reset;
    logic        enable;
    logic [7:0]  chan_mask;
    logic        s_axis_tvalid;
    logic [7:0]  s_axis_tdata;
    logic        mic_clk_en;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tlast;
    logic        busy;
    logic [15:0] overflow_count;

    pdm_capture_sequencer #(
        .NUM_MIC_PAIRS(NP),
        .AXI_STREAM_BYTES(NB),
        .WAKE_CYCLES(WAKE),
        .FRAME_LEN(FL)
    ) dut (
        .pdm_clk(pdm_clk),
        .io_reset(io_reset),
        .enable(enable),
        .chan_mask(chan_mask),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata(s_axis_tdata),
        .mic_clk_en(mic_clk_en),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .busy(busy),
        .overflow_count(overflow_count)
    );

    initial begin
        pdm_clk = 1'b0;
        forever #5 pdm_clk = ~pdm_clk;
    end

    int checks = 0;
    int errors = 0;

    // reference model state
    bit   m_on;
    int   m_warm_left;
    bit   m_stopping;
    int   m_frame_pos;
    int   m_occ;
    int   m_ovf;
    logic [8:0] exp_q[$];

    // monitor observations
    int         n_beats = 0;
    logic [7:0] first_data = '0;
    logic [7:0] last_data = '0;
    logic       last_last = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_warm_left = 0; m_stopping = 0;
        m_frame_pos = 0; m_occ = 0; m_ovf = 0;
        exp_q.delete();
    endtask

    task automatic try_push(input bit pop, input logic [7:0] d, output bit acc);
        acc = 0;
        if (m_occ < 2 || pop) begin
            exp_q.push_back({(m_frame_pos == FL - 1), d});
            m_frame_pos = (m_frame_pos + 1) % FL;
            acc = 1;
        end else if (m_ovf < 65535) begin
            m_ovf++;
        end
    endtask

    // One clock of behaviour, evaluated on the inputs present for that cycle.
    task automatic model_eval();
        bit pop;
        bit acc;
        logic [7:0] d;
        pop = (m_occ > 0) && m_axis_tready;
        acc = 0;
        d   = s_axis_tdata & chan_mask;
        if (!m_on) begin
            if (enable) begin
                m_on = 1;
                m_warm_left = WAKE;
            end
        end else if (m_warm_left > 0) begin
            if (!enable) m_on = 0;
            else m_warm_left--;
        end else if (!m_stopping) begin
            if (s_axis_tvalid) try_push(pop, d, acc);
            if (!enable) m_stopping = 1;
        end else if (m_frame_pos != 0) begin
            if (s_axis_tvalid) try_push(pop, d, acc);
        end else if (m_occ == 0) begin
            m_on = 0;
            m_stopping = 0;
        end
        m_occ = m_occ + int'(acc) - int'(pop);
    endtask

    task automatic step();
        model_eval();
        @(posedge pdm_clk);
        #1;
        chk("busy", int'(busy), int'(m_on));
        chk("mic_clk_en", int'(mic_clk_en), int'(m_on));
        chk("overflow_count", int'(overflow_count), m_ovf);
        chk("tvalid", int'(m_axis_tvalid), int'(m_occ > 0));
    endtask

    // Monitor: pops the scoreboard on each handshake, checks hold stability.
    initial begin
        bit         hold;
        logic [8:0] held;
        logic [8:0] e;
        hold = 0;
        held = '0;
        forever begin
            @(negedge pdm_clk);
            if (io_reset) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk("hold_tvalid", int'(m_axis_tvalid), 1);
                    chk("hold_beat", int'({m_axis_tlast, m_axis_tdata}), int'(held));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", int'({m_axis_tlast, m_axis_tdata}), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", int'({m_axis_tlast, m_axis_tdata}), int'(e));
                    end
                    if (n_beats == 0) first_data = m_axis_tdata;
                    last_data = m_axis_tdata;
                    last_last = m_axis_tlast;
                    n_beats++;
                end
                hold = m_axis_tvalid && !m_axis_tready;
                held = {m_axis_tlast, m_axis_tdata};
            end
        end
    end

    initial begin
        int nb;
        int k;
        bit done;

        io_reset = 1'b1;
        enable = 1'b0;
        chan_mask = 8'hFF;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = 8'h00;
        m_axis_tready = 1'b1;
        model_reset();
        #12;
        chk("rst_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mic", int'(mic_clk_en), 0);
        chk("rst_tdata", int'(m_axis_tdata), 0);
        chk("rst_tlast", int'(m_axis_tlast), 0);
        chk("rst_ovf", int'(overflow_count), 0);
        @(negedge pdm_clk);
        io_reset = 1'b0;
        @(posedge pdm_clk);
        #1;

        // Wake gating with incrementing data
        enable = 1'b1;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata = 8'(i);
            step();
        end
        chk("wake_first_beat", int'(first_data), 5);
        chk("wake_beat_count", n_beats, 14);

        // Channel mask
        s_axis_tdata = 8'hFF;
        chan_mask = 8'hA5;
        for (int i = 0; i < 8; i++) step();
        chan_mask = 8'h0F;
        for (int i = 0; i < 4; i++) step();
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mask_last_beat", int'(last_data), 8'h0F);

        // Backpressure: 10 cycles stalled, 2 held, 8 dropped
        nb = m_ovf;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_axis_tdata = 8'($urandom);
            step();
        end
        chk("bp_overflow", int'(overflow_count), nb + 8);
        chk("bp_tvalid", int'(m_axis_tvalid), 1);

        // Saturation near the top of the counter
        force dut.ovf_cnt_q = 16'hFFFE;
        m_ovf = 16'hFFFE;
        #1;
        release dut.ovf_cnt_q;
        step();
        step();
        chk("ovf_saturated", int'(overflow_count), 16'hFFFF);
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Graceful stop after the 2nd beat of a frame, enable re-raised in drain
        s_axis_tvalid = 1'b1;
        k = 0;
        while (m_frame_pos != 2 && k < 20) begin
            s_axis_tdata = 8'($urandom);
            step();
            k++;
        end
        chk("stop_align", m_frame_pos, 2);
        enable = 1'b0;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (i == 2) enable = 1'b1;
            s_axis_tdata = 8'($urandom);
            step();
            if (!m_on) done = 1;
        end
        chk("stop_reached_idle", int'(done), 1);
        chk("stop_busy", int'(busy), 0);
        chk("stop_last_tlast", int'(last_last), 1);
        step();
        chk("stop_rewake", int'(busy), 1);

        // Abort in WAKE
        enable = 1'b0;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            if (!m_on) done = 1;
        end
        chk("abort_pre_idle", int'(done), 1);
        nb = n_beats;
        enable = 1'b1;
        step();
        step();
        enable = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("abort_no_beats", n_beats, nb);
        chk("abort_idle", int'(busy), 0);

        // Async reset mid-RUN with the buffer full
        enable = 1'b1;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_axis_tdata = 8'($urandom);
            step();
        end
        chk("pre_rst_tvalid", int'(m_axis_tvalid), 1);
        #2;
        io_reset = 1'b1;
        #1;
        chk("mid_rst_tvalid", int'(m_axis_tvalid), 0);
        chk("mid_rst_mic", int'(mic_clk_en), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ovf", int'(overflow_count), 0);
        model_reset();
        @(negedge pdm_clk);
        #2;
        io_reset = 1'b0;
        m_axis_tready = 1'b1;
        nb = n_beats;
        for (int i = 0; i < 5; i++) begin
            s_axis_tdata = 8'($urandom);
            step();
        end
        chk("rewake_no_beats", n_beats, nb);
        for (int i = 0; i < 6; i++) begin
            s_axis_tdata = 8'($urandom);
            step();
        end

        // Random phase
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(63) == 0) enable = ~enable;
            if ($urandom_range(31) == 0) chan_mask = 8'($urandom);
            s_axis_tvalid = ($urandom_range(3) != 0);
            s_axis_tdata  = 8'($urandom);
            m_axis_tready = ($urandom_range(2) != 0);
            step();
        end

        // Final drain
        enable = 1'b0;
        m_axis_tready = 1'b1;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            s_axis_tvalid = ($urandom_range(1) != 0);
            s_axis_tdata  = 8'($urandom);
            step();
            if (!m_on) done = 1;
        end
        chk("final_idle", int'(done), 1);
        step();
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdm_capture_sequencer.md
Name: pdm_capture_sequencer

Overview:
- Run/stop sequencer for the PDM mic-array capture path, in the pdm_clk domain.
- Gates the mic clock and enforces the microphone wake-up interval, discarding samples taken during it.
- Masks disabled channels and forwards the raw deinterleaved bit-vector stream as framed AXI-Stream beats with tlast; the capture path cannot be stalled.
- Absorbs downstream backpressure in a 2-entry buffer and counts samples dropped on overflow.

Parameters:
- NUM_MIC_PAIRS, 4, mic pairs; each pair gives 2 channel bits per sample.
- AXI_STREAM_BYTES, 1, stream width in bytes; must satisfy 8*AXI_STREAM_BYTES >= 2*NUM_MIC_PAIRS.
- WAKE_CYCLES, 48000, pdm_clk cycles of running clock before data is valid (10 ms at 4.8 MHz); must be >= 1.
- FRAME_LEN, 256, beats per frame; m_axis_tlast marks the last beat; must be >= 2.

Ports:
- pdm_clk  in  1  capture clock; all logic on rising edge.
- io_reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = capture requested.
- chan_mask  in  2*NUM_MIC_PAIRS  per-channel enable; 0 forces that tdata bit to 0. Sampled every beat.
- s_axis_tvalid  in  1  sample from capture path; no tready, cannot stall.
- s_axis_tdata  in  8*AXI_STREAM_BYTES  raw channel bits.
- mic_clk_en  out  1  enables the mic clock output driver.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  8*AXI_STREAM_BYTES  masked sample; bits >= 2*NUM_MIC_PAIRS are always 0.
- m_axis_tlast  out  1  last beat of frame.
- busy  out  1  state != IDLE.
- overflow_count  out  16  dropped samples since reset; saturates at 0xFFFF.

Behaviour:
- Reset values: state IDLE; mic_clk_en, m_axis_tvalid, m_axis_tlast, busy = 0; m_axis_tdata = 0; FIFO empty; frame counter 0; wake counter 0; overflow_count 0. Reset asserted mid-operation clears everything immediately. Buffered data is lost and no partial-frame completion is required.
- IDLE: mic_clk_en = 0; input ignored. enable = 1 moves to WAKE on the next edge and loads the wake counter.
- WAKE: mic_clk_en = 1; input discarded and not counted as overflow.
  - After exactly WAKE_CYCLES cycles in WAKE, the next state is RUN.
  - enable = 0 in WAKE returns to IDLE on the next edge; nothing is emitted.
- RUN: mic_clk_en = 1. Each s_axis_tvalid cycle is a push of (s_axis_tdata AND chan_mask, zero-extended).
  - tlast is set on the push where frame count = FRAME_LEN-1; the frame counter then wraps to 0.
  - enable = 0 moves to STOP.
- STOP: pushes continue until the push carrying tlast. After that, input is ignored; wait for FIFO empty, then go to IDLE. No partial frames are ever emitted.
  - enable returning to 1 during STOP is ignored; IDLE re-evaluates enable on the following cycle.
  - If STOP is entered with frame count = 0, no new frame is started: go straight to draining, then IDLE.
- FIFO: 2 entries of {tlast, tdata}. Output is registered; m_axis_tdata, m_axis_tlast and m_axis_tvalid come from the head entry.
  - Latency: first-word fall-through after one register stage. A push at edge N gives m_axis_tvalid = 1 after edge N with an empty FIFO.
  - Pop occurs when m_axis_tvalid & m_axis_tready.
  - Push with pop on the same cycle when full is accepted, with no drop.
  - Push when full with no pop: the sample is dropped, overflow_count increments (saturating), and the frame counter does not advance. Dropped samples are never framed, so tlast spacing counts accepted beats only.
- AXI rules: once m_axis_tvalid is asserted, tdata and tlast stay stable until the handshake; tvalid never drops without a pop.
- busy = (state != IDLE).

Test Plan:
- Wake gating. WAKE_CYCLES=4, FRAME_LEN=4, enable=1, s_axis_tvalid held 1 with incrementing tdata from cycle 0, tready=1.
  - mic_clk_en rises one cycle after enable; the first 4 WAKE samples are absent from the output.
  - Output beats are consecutive, with tlast on every 4th beat.
- Channel mask. chan_mask=8'b1010_0101, input 0xFF every cycle -> every output beat is 0xA5. Change the mask to 0x0F mid-stream -> the beat pushed after the change is 0x0F.
- Backpressure. tready=0 for 10 cycles with input every cycle -> 2 beats held stable, overflow_count=8.
  - Frame counter skips the drops: tlast lands on the 4th accepted beat.
  - Saturation check: preload or force 0xFFFF, then one more drop -> stays 0xFFFF.
- Graceful stop. Drop enable after the 2nd beat of a frame -> beats 3 and 4 are still emitted, with tlast on beat 4.
  - FIFO drains, then IDLE; mic_clk_en and busy go to 0 one cycle after the last pop.
  - Raising enable during the drain has no effect until IDLE.
- Abort in WAKE. enable pulses high for 2 cycles with WAKE_CYCLES=4 -> returns to IDLE, zero output beats, overflow_count unchanged.
- Async reset mid-RUN. Assert io_reset between clock edges with the FIFO holding 2 entries -> m_axis_tvalid, mic_clk_en, busy and overflow_count go to 0 immediately; after release with enable=1 the full WAKE interval repeats.
